parity_frame_accumulator: RTL and testbench

Sequential, parametrised parity generator/checker for streams of data words. Each valid word is folded into a running column parity (bitwise XOR across words) and a frame parity bit (XOR of all bits). A registered result is emitted with a checker flag once every FRAME_LEN valid words. It extends the four-input XOR parity function into clocked, multi-word, mode-selectable operation, and feeds link-integrity logic downstream.

---
 rtl/parity_frame_accumulator.sv | 74 +++++++
 tb/tb_parity_frame_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_accumulator.sv
// parity_frame_accumulator: folds valid words into column/frame parity and emits a checked result every FRAME_LEN words
module parity_frame_accumulator #(
  parameter int WIDTH      = 4,
  parameter int FRAME_LEN  = 4,
  parameter int ODD_PARITY = 0,
  localparam int CW = ($clog2(FRAME_LEN + 1) > 1) ? $clog2(FRAME_LEN + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  input  logic             inParity,
  input  logic             inClear,
  output logic [WIDTH-1:0] outColumn,
  output logic             outG,
  output logic             outErr,
  output logic             outValid,
  output logic [CW-1:0]    outCount
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_col, w_col_nxt, w_c;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             w_take, w_last, w_g;
  // accumulator state register; reset drops any partial frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_count <= w_count_nxt;
    end
  end
  // next-state: clear beats a word, the last word completes and restarts the frame
  always_comb begin
    w_c         = r_col ^ inData;
    w_g         = (^w_c) ^ 1'(ODD_PARITY);
    w_take      = inValid & ~inClear;
    w_last      = w_take & (r_count == LAST);
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_count_nxt = r_count;
    if (inClear || w_last) begin
      w_state_nxt = IDLE;
      w_col_nxt   = '0;
      w_count_nxt = '0;
    end else if (w_take) begin
      w_state_nxt = ACCUM;
      w_col_nxt   = w_c;
      w_count_nxt = r_count + 1'b1;
    end
  end
  // result registers update only when a frame completes; outValid pulses for that one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outColumn <= '0;
      outG      <= 1'b0;
      outErr    <= 1'b0;
      outValid  <= 1'b0;
    end else begin
      outValid <= w_last;
      if (w_last) begin
        outColumn <= w_c;
        outG      <= w_g;
        outErr    <= w_g ^ inParity;
      end
    end
  end
  assign outCount = r_count;
endmodule

// File: tb/tb_parity_frame_accumulator.sv
// tb_parity_frame_accumulator: directed and randomized checks of even and odd instances against a queue-based model
module tb_parity_frame_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0, in_parity = 1'b0, in_clear = 1'b0;
  logic [3:0] e_col, o_col;
  logic       e_g, e_err, e_val, o_g, o_err, o_val;
  logic [2:0] e_cnt, o_cnt;
  int checks = 0, failures = 0;
  int q[$];
  logic [3:0] m_col;
  logic       m_g, m_err, m_g_o, m_err_o, m_val;
  logic [2:0] m_cnt;

  always #5 clk = ~clk;

  parity_frame_accumulator dut_even (
    .clk(clk), .rst_n(rst_n), .inData(in_data), .inValid(in_valid), .inParity(in_parity), .inClear(in_clear),
    .outColumn(e_col), .outG(e_g), .outErr(e_err), .outValid(e_val), .outCount(e_cnt));

  parity_frame_accumulator #(.ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .inData(in_data), .inValid(in_valid), .inParity(in_parity), .inClear(in_clear),
    .outColumn(o_col), .outG(o_g), .outErr(o_err), .outValid(o_val), .outCount(o_cnt));

  task automatic step(input logic v, input logic [3:0] d, input logic p, input logic c);
    logic [3:0] x;
    in_valid = v; in_data = d; in_parity = p; in_clear = c;
    @(posedge clk);
    m_val = 1'b0;
    if (!rst_n) begin
      q.delete();
      {m_col, m_g, m_err, m_g_o, m_err_o} = '0;
    end else if (c) begin
      q.delete();
    end else if (v) begin
      q.push_back(int'(d));
      if (q.size() == 4) begin
        x = '0;
        foreach (q[i]) x = x ^ q[i][3:0];
        m_col = x;
        m_g = ($countones(x) % 2) == 1;
        m_g_o = !m_g;
        m_err = m_g != p;
        m_err_o = m_g_o != p;
        m_val = 1'b1;
        q.delete();
      end
    end
    m_cnt = 3'(q.size());
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'hF, 1'b0, 1'b0);
      checks++;
      if ({e_col, e_g, e_err, e_val, e_cnt} !== 10'd0 || {o_col, o_g, o_err, o_val, o_cnt} !== 10'd0) begin
        failures++;
        $display("FAIL reset cyc=%0d even=%h odd=%h expected all zero", i,
                 {e_col, e_g, e_err, e_val, e_cnt}, {o_col, o_g, o_err, o_val, o_cnt});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_contiguous();
    logic [3:0] w[4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i], 1'b0, 1'b0);
      if (i < 3) begin
        checks++;
        if (e_val !== 1'b0 || e_cnt !== 3'(i + 1)) begin
          failures++;
          $display("FAIL contig_partial i=%0d val=%b cnt=%0d expected val=0 cnt=%0d", i, e_val, e_cnt, i + 1);
        end
      end
    end
    checks++;
    if ({e_val, e_col, e_g, e_err, e_cnt} !== {1'b1, 4'hF, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL contig_result val=%b col=%h g=%b err=%b cnt=%0d expected 1 F 0 0 0", e_val, e_col, e_g, e_err, e_cnt);
    end
  endtask

  task automatic test_gaps();
    logic       v[7] = '{1, 0, 1, 1, 0, 0, 1};
    logic [3:0] d[7] = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    logic [2:0] c[7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0};
    for (int i = 0; i < 7; i++) begin
      step(v[i], d[i], 1'b0, 1'b0);
      checks++;
      if (e_cnt !== c[i] || e_val !== (i == 6)) begin
        failures++;
        $display("FAIL gaps_count i=%0d cnt=%0d val=%b expected cnt=%0d val=%b", i, e_cnt, e_val, c[i], i == 6);
      end
    end
    checks++;
    if ({e_col, e_g, e_err} !== {4'h2, 1'b1, 1'b1} || {o_col, o_g, o_err} !== {4'h2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL gaps_result even=%h/%b/%b odd=%h/%b/%b expected 2/1/1 and 2/0/0", e_col, e_g, e_err, o_col, o_g, o_err);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, first = -1, last = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'hF, 1'b0, 1'b0);
      if (e_val) begin
        n++;
        if (first < 0) first = i; else last = i;
        checks++;
        if (e_col !== 4'h0 || e_g !== 1'b0) begin
          failures++;
          $display("FAIL b2b_result i=%0d col=%h g=%b expected 0 0", i, e_col, e_g);
        end
      end
    end
    checks++;
    if (n != 2 || last - first != 4) begin
      failures++;
      $display("FAIL b2b_pulses count=%0d spacing=%0d expected 2 and 4", n, last - first);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    checks++;
    if (e_cnt !== 3'd0 || e_val !== 1'b0) begin
      failures++;
      $display("FAIL clear_count cnt=%0d val=%b expected 0 0", e_cnt, e_val);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h1, 1'b0, 1'b0);
      if (e_val) n++;
    end
    checks++;
    if (n != 1 || e_val !== 1'b1 || e_col !== 4'h0 || e_g !== 1'b0) begin
      failures++;
      $display("FAIL clear_recovery pulses=%0d val=%b col=%h g=%b expected 1 1 0 0", n, e_val, e_col, e_g);
    end
  endtask

  task automatic test_reset_odd();
    logic [3:0] w[4] = '{4'h1, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 3; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checks++;
    if ({e_col, e_g, e_err, e_val, e_cnt} !== 10'd0 || o_cnt !== 3'd0) begin
      failures++;
      $display("FAIL midreset even=%h odd_cnt=%0d expected all zero", {e_col, e_g, e_err, e_val, e_cnt}, o_cnt);
    end
    for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 1'b0);
    checks++;
    if ({e_val, e_col, e_g, e_err} !== {1'b1, 4'h1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL midreset_even val=%b col=%h g=%b err=%b expected 1 1 1 1", e_val, e_col, e_g, e_err);
    end
    checks++;
    if ({o_val, o_col, o_g, o_err} !== {1'b1, 4'h1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL odd_mode val=%b col=%h g=%b err=%b expected 1 1 0 0", o_val, o_col, o_g, o_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 49) != 0;
      step($urandom_range(0, 9) < 7, 4'($urandom), 1'($urandom), $urandom_range(0, 11) == 0);
      checks++;
      if ({e_col, e_g, e_err, e_val, e_cnt} !== {m_col, m_g, m_err, m_val, m_cnt}) begin
        failures++;
        $display("FAIL rand_even cyc=%0d got=%h expected=%h", i, {e_col, e_g, e_err, e_val, e_cnt}, {m_col, m_g, m_err, m_val, m_cnt});
      end
      checks++;
      if ({o_col, o_g, o_err, o_val, o_cnt} !== {m_col, m_g_o, m_err_o, m_val, m_cnt}) begin
        failures++;
        $display("FAIL rand_odd cyc=%0d got=%h expected=%h", i, {o_col, o_g, o_err, o_val, o_cnt}, {m_col, m_g_o, m_err_o, m_val, m_cnt});
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_reset_odd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
